// File: rtl/data_bus_sched.sv
// Mode scheduler: host writes are shadowed and applied only on a sweep trig, followed by blanking; auto mode alternates MTI/NV phases.
// Define SIM_PATTERN_EN to enable the 8-bit LFSR simulated-data source (data_source/simulate tie to 0 otherwise).
module data_bus_sched #(
  parameter int GUARD_CYC = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             cfg_wr,
  input  logic             cfg_nv,
  input  logic             cfg_mti,
  input  logic             cfg_auto,
  input  logic             cfg_src,
  input  logic [CNT_W-1:0] cfg_n_mti,
  input  logic [CNT_W-1:0] cfg_n_nv,
  output logic             cfg_ack,
  output logic             mode_nv,
  output logic             mode_mti_nv,
  output logic             mode_auto,
  output logic             auto,
  output logic             data_source,
  output logic             simulate,
  output logic             blank,
  output logic [CNT_W-1:0] sweep_cnt
);

  typedef enum logic [1:0] {WAIT_TRIG, RUN, GUARD} state_t;

  localparam logic [3:0]       GUARD_LAST = 4'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [3:0]       guard_cnt;
  logic             pending;
  logic             phase;
  logic             sh_nv, sh_mti, sh_auto, sh_src;
  logic [CNT_W-1:0] sh_n_mti, sh_n_nv;
  logic [CNT_W-1:0] n_mti_act, n_nv_act;

  logic apply, next_auto, at_last, phase_flip;

  // Last sweep index of a phase; a programmed length of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - CNT_ONE;
  endfunction

  // A trig applies the shadow as it stood before any coincident write.
  always_comb begin
    apply      = trig && pending;
    next_auto  = apply ? sh_auto : mode_auto;
    at_last    = sweep_cnt >= last_idx(phase ? n_mti_act : n_nv_act);
    phase_flip = trig && mode_auto && next_auto && at_last;
  end

  assign auto = mode_auto & phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ack  <= 1'b0;
      pending  <= 1'b0;
      sh_nv    <= 1'b0;
      sh_mti   <= 1'b0;
      sh_auto  <= 1'b0;
      sh_src   <= 1'b0;
      sh_n_mti <= '0;
      sh_n_nv  <= '0;
    end else begin
      cfg_ack <= cfg_wr;
      if (cfg_wr) begin
        sh_nv    <= cfg_nv;
        sh_mti   <= cfg_mti;
        sh_auto  <= cfg_auto;
        sh_src   <= cfg_src;
        sh_n_mti <= cfg_n_mti;
        sh_n_nv  <= cfg_n_nv;
        pending  <= 1'b1;
      end else if (trig) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_nv     <= 1'b0;
      mode_mti_nv <= 1'b0;
      mode_auto   <= 1'b0;
      n_mti_act   <= '0;
      n_nv_act    <= '0;
    end else if (apply) begin
      mode_nv     <= sh_nv;
      mode_mti_nv <= sh_mti;
      mode_auto   <= sh_auto;
      n_mti_act   <= sh_n_mti;
      n_nv_act    <= sh_n_nv;
    end
  end

  // Auto sequencer: a sweep counts only when auto was already running and stays on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b1;
      sweep_cnt <= '0;
    end else if (trig) begin
      if (mode_auto && next_auto) begin
        if (at_last) begin
          phase     <= ~phase;
          sweep_cnt <= '0;
        end else begin
          sweep_cnt <= sweep_cnt + CNT_ONE;
        end
      end else begin
        phase     <= 1'b1;
        sweep_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_TRIG;
      guard_cnt <= '0;
      blank     <= 1'b1;
    end else begin
      case (state)
        WAIT_TRIG: begin
          if (trig) begin
            state     <= GUARD;
            guard_cnt <= '0;
            blank     <= 1'b1;
          end
        end
        RUN: begin
          if (trig && (pending || phase_flip)) begin
            state     <= GUARD;
            guard_cnt <= '0;
            blank     <= 1'b1;
          end
        end
        GUARD: begin
          if (trig) begin
            guard_cnt <= '0;
          end else if (guard_cnt == GUARD_LAST) begin
            state <= RUN;
            blank <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt + 4'd1;
          end
        end
        default: begin
          state     <= WAIT_TRIG;
          guard_cnt <= '0;
          blank     <= 1'b1;
        end
      endcase
    end
  end

`ifdef SIM_PATTERN_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward bit 0; restarted by every trig.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= 8'h01;
      data_source <= 1'b0;
    end else begin
      if (trig) lfsr <= 8'h01;
      else      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
      if (apply) data_source <= sh_src;
    end
  end

  assign simulate = data_source & lfsr[0];
`else
  logic unused_src;

  assign unused_src  = sh_src;
  assign data_source = 1'b0;
  assign simulate    = 1'b0;
`endif

endmodule

// File: doc/data_bus_sched.md
DATA_BUS_SCHED -- requirements
Module: data_bus_sched

Interface
REQ-001 SHALL have parameter GUARD_CYC, default 4: number of blanking cycles after any applied mode change (1..15).
REQ-002 SHALL have parameter CNT_W, default 4: width of the sweep counters and the auto-sequence length fields.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock; all state on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- trig, in, 1: sweep-start pulse, one clk wide.
- cfg_wr, in, 1: host write strobe; captures all cfg_* inputs.
- cfg_nv, in, 1: requested NV bit-source select.
- cfg_mti, in, 1: requested manual MTI/NV select.
- cfg_auto, in, 1: requested auto-alternation enable.
- cfg_src, in, 1: requested data source (1 = simulate).
- cfg_n_mti, in, CNT_W: sweeps per MTI phase in auto mode.
- cfg_n_nv, in, CNT_W: sweeps per NV phase in auto mode.
- cfg_ack, out, 1: one-cycle acknowledge of cfg_wr.
- mode_nv, out, 1: active NV bit-source select.
- mode_mti_nv, out, 1: active manual MTI/NV select.
- mode_auto, out, 1: active auto enable.
- auto, out, 1: auto-sequencer MTI/NV select.
- data_source, out, 1: active source select.
- simulate, out, 1: simulated bit stream.
- blank, out, 1: downstream data invalid.
- sweep_cnt, out, CNT_W: sweep index within the current auto phase.

Function
REQ-005 SHALL capture cfg_* into shadow registers on any clk edge with cfg_wr=1, set a pending flag, and assert cfg_ack for exactly the next cycle; back-to-back writes SHALL each be acked, and the last write wins.
REQ-006 SHALL change the active outputs mode_nv, mode_mti_nv, mode_auto and data_source only on a trig edge while pending=1, then clear pending; the outputs SHALL never change mid-sweep.
REQ-007 If cfg_wr and trig coincide, the trig SHALL apply the shadow contents held before that write; the new write SHALL remain pending until the next trig.
REQ-008 SHALL implement an FSM with states WAIT_TRIG, RUN and GUARD, using these transitions:
- WAIT_TRIG -trig-> GUARD.
- RUN -trig with pending or auto phase toggle-> GUARD.
- RUN -trig, no change-> RUN.
- GUARD -guard count reaches GUARD_CYC-> RUN.
- GUARD -trig-> GUARD, restarting the guard count and counting the trig as a sweep.
REQ-009 blank SHALL be 1 in WAIT_TRIG and GUARD, and 0 in RUN, registered with the same timing as the state.
REQ-010 SHALL drive the auto sequencer as follows:
- auto = mode_auto AND phase.
- phase SHALL be 1 (MTI) when mode_auto becomes active.
- sweep_cnt SHALL increment on each trig while mode_auto=1.
- When a trig arrives with sweep_cnt = N-1 (N = n_mti for MTI, n_nv for NV), phase SHALL toggle and sweep_cnt SHALL clear.
REQ-011 An applied N of 0 SHALL be treated as 1; N SHALL wrap at 2^CNT_W-1 and never overflow sweep_cnt.
REQ-012 While mode_auto=0, sweep_cnt SHALL be held at 0; applying mode_auto 1->0 SHALL clear phase to 1.

Reset
REQ-013 On rst_n=0 the block SHALL set the following, regardless of state or pending writes:
- State WAIT_TRIG, blank=1, cfg_ack=0, pending=0, phase=1.
- mode_nv, mode_mti_nv, mode_auto, auto, data_source and simulate all 0.
- sweep_cnt=0, shadow registers 0.
REQ-014 Reset mid-GUARD or mid-sweep SHALL discard the guard count and any pending configuration.

Configuration
REQ-015 With SIM_PATTERN_EN defined, the block SHALL include an 8-bit Fibonacci LFSR with the following behaviour:
- Polynomial x^8+x^6+x^5+x^4+1.
- Seeded to 0x01 by reset and by every trig.
- Advances every clk.
- simulate = lfsr[0].
- data_source follows the applied cfg_src.
REQ-016 Without SIM_PATTERN_EN, simulate SHALL be constant 0, data_source constant 0, and cfg_src ignored (captured but unused).

Verification
REQ-017 Reset release, no trig for 100 cycles -> all mode outputs 0, blank=1, state WAIT_TRIG.
REQ-018 cfg_wr with cfg_nv=1, then trig 10 cycles later -> cfg_ack high one cycle after the write; mode_nv stays 0 until the trig edge, then 1; blank=1 for exactly 4 cycles, then 0.
REQ-019 cfg_auto=1, n_mti=2, n_nv=3, trig every 20 cycles -> auto pattern over sweeps is 1,1,0,0,0,1,1,...; sweep_cnt is 0,1,0,1,2,0,1; blank asserts after each phase toggle.
REQ-020 cfg_wr coincident with trig -> old configuration kept for that sweep; new configuration applied at the following trig.
REQ-021 rst_n pulsed low during GUARD with a pending write -> outputs return to reset values; a subsequent trig applies nothing.
REQ-022 With SIM_PATTERN_EN and cfg_src=1 applied -> the first 8 simulate bits after a trig match the LFSR reference sequence seeded 0x01; without the macro, simulate stays 0.
